// File: rtl/neuron_train_driver2.sv
`default_nettype none
// ============================================================================
// Module      : neuron_train_driver2
// Description : Training/inference sequencer for a 2-output learning layer.
//               Accepts labelled samples on a valid/ready handshake, strobes a
//               forward pass, waits SETTLE cycles, classifies the layer output
//               by argmax, reports the result, keeps saturating sample/error
//               counts and optionally issues a learn pass with a one-hot
//               teacher target.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_train_driver2 #(
    parameter int N      = 16,  // inputs per sample
    parameter int SETTLE = 2,   // cycles from forward strobe to evaluation (>=1)
    parameter int CNT_W  = 16,  // width of the running counters
    parameter int DATA_W = 8    // width of one zero-to-one fixed-point value
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_train_en,
    input  logic                       i_s_valid,
    output logic                       o_s_ready,
    input  logic [N-1:0][DATA_W-1:0]   i_s_in,
    input  logic                       i_s_label,
    output logic [N-1:0][DATA_W-1:0]   o_layer_in,
    output logic                       o_layer_valid,
    output logic                       o_layer_learn,
    output logic [1:0][DATA_W-1:0]     o_layer_expected,
    input  logic [1:0][DATA_W-1:0]     i_layer_out,
    output logic                       o_r_valid,
    output logic                       o_r_class,
    output logic                       o_r_correct,
    output logic [CNT_W-1:0]           o_sample_count,
    output logic [CNT_W-1:0]           o_error_count
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0]  c_SETTLE_LOAD = SET_W'(SETTLE - 1);
    localparam logic [DATA_W-1:0] c_ONE         = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FWD   = 3'd1,
        S_WAIT  = 3'd2,
        S_EVAL  = 3'd3,
        S_LEARN = 3'd4
    } state_t;

    state_t                     r_state;
    logic [SET_W-1:0]           r_settle;
    logic                       r_label;
    logic                       r_s_ready;
    logic [N-1:0][DATA_W-1:0]   r_layer_in;
    logic                       r_layer_valid;
    logic                       r_layer_learn;
    logic [1:0][DATA_W-1:0]     r_layer_expected;
    logic                       r_r_valid;
    logic                       r_r_class;
    logic                       r_r_correct;
    logic [CNT_W-1:0]           r_sample_count;
    logic [CNT_W-1:0]           r_error_count;

    logic                       w_pred;
    logic                       w_correct;
    logic [SET_W-1:0]           w_settle_dec;
    logic                       w_enter_eval;

    // Argmax of the layer output (tie resolves to class 0) and settle bookkeeping.
    always_comb begin
        w_pred       = (i_layer_out[1] > i_layer_out[0]);
        w_correct    = (w_pred == r_label);
        w_settle_dec = r_settle - SET_W'(1);
        w_enter_eval = ((r_state == S_FWD)  && (SETTLE == 1)) ||
                       ((r_state == S_WAIT) && (w_settle_dec == '0));
    end

    // Sequencer FSM with registered outputs. The layer output is sampled on
    // the edge that enters EVAL so the result strobe is high during EVAL.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state          <= S_IDLE;
            r_settle         <= '0;
            r_label          <= 1'b0;
            r_s_ready        <= 1'b1;
            r_layer_in       <= '0;
            r_layer_valid    <= 1'b0;
            r_layer_learn    <= 1'b0;
            r_layer_expected <= '0;
            r_r_valid        <= 1'b0;
            r_r_class        <= 1'b0;
            r_r_correct      <= 1'b0;
            r_sample_count   <= '0;
            r_error_count    <= '0;
        end else begin
            r_layer_valid <= 1'b0;
            r_layer_learn <= 1'b0;
            r_r_valid     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_s_valid) begin
                        r_layer_in    <= i_s_in;
                        r_label       <= i_s_label;
                        r_s_ready     <= 1'b0;
                        r_layer_valid <= 1'b1;
                        r_state       <= S_FWD;
                    end
                end
                S_FWD: begin
                    r_settle <= c_SETTLE_LOAD;
                    r_state  <= (SETTLE == 1) ? S_EVAL : S_WAIT;
                end
                S_WAIT: begin
                    r_settle <= w_settle_dec;
                    if (w_settle_dec == '0) begin
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (i_train_en) begin
                        r_layer_learn <= 1'b1;
                        r_state       <= S_LEARN;
                    end else begin
                        r_s_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_LEARN: begin
                    r_s_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_s_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase

            if (w_enter_eval) begin
                r_r_valid   <= 1'b1;
                r_r_class   <= w_pred;
                r_r_correct <= w_correct;
                if (r_sample_count != '1) begin
                    r_sample_count <= r_sample_count + CNT_W'(1);
                end
                if (!w_correct && (r_error_count != '1)) begin
                    r_error_count <= r_error_count + CNT_W'(1);
                end
                r_layer_expected[r_label]  <= c_ONE;
                r_layer_expected[~r_label] <= '0;
            end
        end
    end

    assign o_s_ready        = r_s_ready;
    assign o_layer_in       = r_layer_in;
    assign o_layer_valid    = r_layer_valid;
    assign o_layer_learn    = r_layer_learn;
    assign o_layer_expected = r_layer_expected;
    assign o_r_valid        = r_r_valid;
    assign o_r_class        = r_r_class;
    assign o_r_correct      = r_r_correct;
    assign o_sample_count   = r_sample_count;
    assign o_error_count    = r_error_count;

endmodule
`default_nettype wire

// File: tb/tb_neuron_train_driver2.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_train_driver2
// Description : Self-checking bench for neuron_train_driver2. Acts as the
//               sample source and as a stubbed layer, and compares every
//               sample's handshake/strobe timing, classification, target and
//               counters against a transaction-level reference model. A second
//               instance with 2-bit counters checks saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_train_driver2;

    localparam int N      = 16;
    localparam int SETTLE = 2;
    localparam int DW     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic                   train_en;
    logic                   s_valid;
    logic                   s_label;
    logic [N-1:0][DW-1:0]   s_in;
    logic [1:0][DW-1:0]     layer_out;

    logic                   s_ready;
    logic [N-1:0][DW-1:0]   layer_in;
    logic                   layer_valid;
    logic                   layer_learn;
    logic [1:0][DW-1:0]     layer_expected;
    logic                   r_valid;
    logic                   r_class;
    logic                   r_correct;
    logic [15:0]            sample_count;
    logic [15:0]            error_count;

    logic                   sat_s_ready;
    logic [N-1:0][DW-1:0]   sat_layer_in;
    logic                   sat_layer_valid;
    logic                   sat_layer_learn;
    logic [1:0][DW-1:0]     sat_layer_expected;
    logic                   sat_r_valid;
    logic                   sat_r_class;
    logic                   sat_r_correct;
    logic [1:0]             sat_sample_count;
    logic [1:0]             sat_error_count;

    neuron_train_driver2 #(.N(N), .SETTLE(SETTLE), .CNT_W(16), .DATA_W(DW)) u_dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_train_en       (train_en),
        .i_s_valid        (s_valid),
        .o_s_ready        (s_ready),
        .i_s_in           (s_in),
        .i_s_label        (s_label),
        .o_layer_in       (layer_in),
        .o_layer_valid    (layer_valid),
        .o_layer_learn    (layer_learn),
        .o_layer_expected (layer_expected),
        .i_layer_out      (layer_out),
        .o_r_valid        (r_valid),
        .o_r_class        (r_class),
        .o_r_correct      (r_correct),
        .o_sample_count   (sample_count),
        .o_error_count    (error_count)
    );

    neuron_train_driver2 #(.N(N), .SETTLE(SETTLE), .CNT_W(2), .DATA_W(DW)) u_sat (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_train_en       (train_en),
        .i_s_valid        (s_valid),
        .o_s_ready        (sat_s_ready),
        .i_s_in           (s_in),
        .i_s_label        (s_label),
        .o_layer_in       (sat_layer_in),
        .o_layer_valid    (sat_layer_valid),
        .o_layer_learn    (sat_layer_learn),
        .o_layer_expected (sat_layer_expected),
        .i_layer_out      (layer_out),
        .o_r_valid        (sat_r_valid),
        .o_r_class        (sat_r_class),
        .o_r_correct      (sat_r_correct),
        .o_sample_count   (sat_sample_count),
        .o_error_count    (sat_error_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: completed samples and mispredictions (unbounded).
    int m_samples = 0;
    int m_wrong   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    task automatic chk_counts();
        chk("sample_count",     sample_count,     sat(m_samples, 65535));
        chk("error_count",      error_count,      sat(m_wrong,   65535));
        chk("sat_sample_count", sat_sample_count, sat(m_samples, 3));
        chk("sat_error_count",  sat_error_count,  sat(m_wrong,   3));
    endtask

    // One full sample, entered and left on a negedge where the driver is idle.
    // Timeline from the accept edge T: forward strobe in cycle T+1, result in
    // T+SETTLE+1, learn (train mode) one cycle later, then ready again.
    task automatic run_sample(input logic lbl, input logic [DW-1:0] o0,
                              input logic [DW-1:0] o1, input logic tr);
        logic [N-1:0][DW-1:0] smp;
        logic [1:0][DW-1:0]   tgt;
        logic                 cls;
        for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
        cls        = (o1 > o0);
        tgt[lbl]   = {DW{1'b1}};
        tgt[~lbl]  = '0;

        chk("ready_idle", s_ready, 1'b1);
        s_valid   = 1'b1;
        s_in      = smp;
        s_label   = lbl;
        layer_out = {o1, o0};
        train_en  = 1'(~tr);

        @(negedge clk);   // forward cycle
        chk("fwd_layer_valid", layer_valid, 1'b1);
        chk("fwd_learn",       layer_learn, 1'b0);
        chk("fwd_r_valid",     r_valid,     1'b0);
        chk("fwd_ready",       s_ready,     1'b0);
        chk("fwd_layer_in",    layer_in,    smp);
        // Keep offering junk: it must not be captured while busy.
        s_in     = ~smp;
        s_label  = ~lbl;
        train_en = (SETTLE > 1) ? 1'(~tr) : tr;

        for (int k = 0; k < SETTLE - 1; k++) begin
            @(negedge clk);   // settle cycles
            chk("wait_layer_valid", layer_valid, 1'b0);
            chk("wait_r_valid",     r_valid,     1'b0);
            chk("wait_ready",       s_ready,     1'b0);
            chk("wait_layer_in",    layer_in,    smp);
            train_en = tr;
        end

        @(negedge clk);   // evaluation cycle
        m_samples++;
        if (cls != lbl) m_wrong++;
        chk("eval_r_valid",     r_valid,        1'b1);
        chk("eval_r_class",     r_class,        cls);
        chk("eval_r_correct",   r_correct,      (cls == lbl));
        chk("eval_layer_valid", layer_valid,    1'b0);
        chk("eval_learn",       layer_learn,    1'b0);
        chk("eval_ready",       s_ready,        1'b0);
        chk("eval_expected",    layer_expected, tgt);
        chk("eval_layer_in",    layer_in,       smp);
        chk_counts();
        s_valid   = 1'b0;
        layer_out = {DW'($urandom), DW'($urandom)};

        @(negedge clk);
        chk("post_r_valid",     r_valid,     1'b0);
        chk("post_layer_valid", layer_valid, 1'b0);
        chk("post_learn",       layer_learn, tr);
        if (tr) begin
            chk("learn_expected", layer_expected, tgt);
            chk("learn_layer_in", layer_in,       smp);
            chk("learn_ready",    s_ready,        1'b0);
            train_en = 1'($urandom);
            @(negedge clk);
            chk("idle_learn", layer_learn, 1'b0);
        end
        chk("return_ready", s_ready, 1'b1);
    endtask

    // Accept a sample, then assert reset during the settle cycle.
    task automatic reset_in_wait();
        chk("ready_idle", s_ready, 1'b1);
        s_valid   = 1'b1;
        s_label   = 1'b0;
        for (int i = 0; i < N; i++) s_in[i] = DW'($urandom);
        layer_out = {8'd10, 8'd200};
        train_en  = 1'b1;
        @(negedge clk);   // forward cycle
        chk("rst_fwd_layer_valid", layer_valid, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);   // settle cycle
        rst_n = 1'b0;
        @(negedge clk);
        m_samples = 0;
        m_wrong   = 0;
        chk("rst_r_valid",  r_valid,        1'b0);
        chk("rst_learn",    layer_learn,    1'b0);
        chk("rst_ready",    s_ready,        1'b1);
        chk("rst_layer_in", layer_in,       '0);
        chk("rst_expected", layer_expected, '0);
        chk_counts();
        rst_n = 1'b1;
        for (int k = 0; k < SETTLE + 2; k++) begin
            @(negedge clk);
            chk("rst_after_r_valid", r_valid,     1'b0);
            chk("rst_after_learn",   layer_learn, 1'b0);
            chk("rst_after_ready",   s_ready,     1'b1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        train_en  = 1'b0;
        s_valid   = 1'b0;
        s_label   = 1'b0;
        s_in      = '0;
        layer_out = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready",       s_ready,        1'b1);
        chk("reset_layer_valid", layer_valid,    1'b0);
        chk("reset_learn",       layer_learn,    1'b0);
        chk("reset_r_valid",     r_valid,        1'b0);
        chk("reset_layer_in",    layer_in,       '0);
        chk("reset_expected",    layer_expected, '0);
        chk_counts();
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: inference correct, train wrong, tie, saturation.
        run_sample(1'b0, 8'd192, 8'd64,  1'b0);
        run_sample(1'b0, 8'd51,  8'd204, 1'b1);
        run_sample(1'b1, 8'd128, 8'd128, 1'b0);
        for (int s = 0; s < 5; s++) run_sample(1'b1, 8'd150, 8'd30, 1'($urandom));

        // Randomized samples with frequent ties.
        for (int s = 0; s < 40; s++) begin
            logic [DW-1:0] o0, o1;
            o0 = DW'($urandom);
            o1 = ($urandom_range(0, 3) == 0) ? o0 : DW'($urandom);
            run_sample(1'($urandom), o0, o1, 1'($urandom));
        end

        reset_in_wait();

        for (int s = 0; s < 10; s++) begin
            run_sample(1'($urandom), DW'($urandom), DW'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
